// File: rtl/icache_pf_pkg.sv
// Shared types for the I-cache prefetch controller: bus commands, queue entry
// layout and the fetch-address to line-address helper.
package icache_pf_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2,
    BUS_INVAL = 2'd3
  } bus_cmd_e;

  localparam int LINE_W    = 61;
  localparam int TAG_MAX_W = 8;

  typedef logic [LINE_W-1:0] line_t;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [TAG_MAX_W-1:0] mem_tag;
    line_t                line_addr;
  } pf_entry_t;

  function automatic line_t line_of(input logic [63:0] addr);
    return line_t'(addr >> 3);
  endfunction

endpackage

// File: rtl/icache_prefetch_ctrl_if.sv
// Memory-bus request/return and I-cache install port of the prefetch controller.
interface icache_prefetch_ctrl_if #(
  parameter int NUM_THREADS  = 2,
  parameter int MEM_TAG_BITS = 4,
  parameter int IDX_BITS     = 5,
  parameter int CTAG_BITS    = 8
);
  import icache_pf_pkg::*;

  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  bus_cmd_e                mem_command;
  logic [63:0]             mem_addr;
  logic [TID_W-1:0]        issue_thread;
  logic [MEM_TAG_BITS-1:0] mem_response;
  logic [MEM_TAG_BITS-1:0] mem_tag;
  logic                    wr_en;
  logic [IDX_BITS-1:0]     wr_index;
  logic [CTAG_BITS-1:0]    wr_tag;

  modport master (
    output mem_command, mem_addr, issue_thread, wr_en, wr_index, wr_tag,
    input  mem_response, mem_tag
  );

  modport slave (
    input  mem_command, mem_addr, issue_thread, wr_en, wr_index, wr_tag,
    output mem_response, mem_tag
  );

endinterface

// File: rtl/icache_pf_queue.sv
// One thread's circular window of outstanding line requests: redirect flush,
// enqueue on grant, tag CAM for returns and in-order retire.
module icache_pf_queue
  import icache_pf_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int MEM_TAG_BITS = 4,
  parameter int CL_W         = 13
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    thread_en,
  input  logic [63:0]             fetch_addr,
  input  logic                    cache_hit,
  input  logic                    grant,
  input  logic [MEM_TAG_BITS-1:0] grant_tag,
  input  logic [MEM_TAG_BITS-1:0] mem_tag,
  output logic                    eligible,
  output line_t                   req_line,
  output logic                    match,
  output logic [CL_W-1:0]         match_cline,
  output logic [$clog2(DEPTH):0]  outstanding
);

  localparam int PTR_W = $clog2(DEPTH);

  pf_entry_t            entry_reg [DEPTH];
  logic [PTR_W:0]       head_reg, tail_reg;
  line_t                next_req_reg, last_line_reg;
  logic                 last_hit_reg;
  logic                 redirect, flush, retire;
  logic [PTR_W-1:0]     head_idx, tail_idx, match_idx;
  logic [TAG_MAX_W-1:0] tag_ext, grant_ext;

  assign tag_ext   = TAG_MAX_W'(mem_tag);
  assign grant_ext = TAG_MAX_W'(grant_tag);
  assign head_idx  = head_reg[PTR_W-1:0];
  assign tail_idx  = tail_reg[PTR_W-1:0];

  assign redirect    = !cache_hit && ((line_of(fetch_addr) != last_line_reg) || last_hit_reg);
  assign flush       = redirect || !thread_en;
  assign outstanding = tail_reg - head_reg;
  assign eligible    = thread_en && !cache_hit && (outstanding < (PTR_W+1)'(DEPTH));
  assign req_line    = redirect ? line_of(fetch_addr) : next_req_reg;
  assign retire      = entry_reg[head_idx].valid && entry_reg[head_idx].done;

  // Descending scan so the lowest matching slot wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (tag_ext != '0 && entry_reg[i].valid && !entry_reg[i].done &&
          entry_reg[i].mem_tag == tag_ext) begin
        match     = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
    match_cline = entry_reg[match_idx].line_addr[CL_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      next_req_reg  <= '0;
      last_line_reg <= '1;
      last_hit_reg  <= 1'b0;
    end else begin
      // A disabled thread forgets its line so re-enabling forces a redirect.
      last_line_reg <= thread_en ? line_of(fetch_addr) : '1;
      last_hit_reg  <= cache_hit;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
        head_reg <= '0;
        if (grant) begin
          entry_reg[0] <= '{valid: 1'b1, done: 1'b0, mem_tag: grant_ext, line_addr: req_line};
          tail_reg     <= (PTR_W+1)'(1);
          next_req_reg <= req_line + 1'b1;
        end else begin
          tail_reg     <= '0;
          next_req_reg <= req_line;
        end
      end else begin
        if (match) entry_reg[match_idx].done <= 1'b1;
        if (retire) begin
          entry_reg[head_idx].valid <= 1'b0;
          entry_reg[head_idx].done  <= 1'b0;
          head_reg                  <= head_reg + 1'b1;
        end
        if (grant) begin
          entry_reg[tail_idx] <= '{valid: 1'b1, done: 1'b0, mem_tag: grant_ext, line_addr: req_line};
          tail_reg            <= tail_reg + 1'b1;
          next_req_reg        <= req_line + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/icache_prefetch_ctrl.sv
// Multi-thread I-cache prefetch controller: per-thread request queues, a
// round-robin bus arbiter and the I-cache install mux.
module icache_prefetch_ctrl
  import icache_pf_pkg::*;
#(
  parameter int NUM_THREADS  = 2,
  parameter int DEPTH        = 4,
  parameter int MEM_TAG_BITS = 4,
  parameter int IDX_BITS     = 5,
  parameter int CTAG_BITS    = 8
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NUM_THREADS-1:0]                   thread_en,
  input  logic [NUM_THREADS-1:0][63:0]             fetch_addr,
  input  logic [NUM_THREADS-1:0]                   cache_hit,
  icache_prefetch_ctrl_if.master                   bus,
  output logic [NUM_THREADS-1:0][$clog2(DEPTH):0]  outstanding
);

  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int CL_W  = IDX_BITS + CTAG_BITS;

  logic [NUM_THREADS-1:0] eligible, grant, match;
  line_t                  req_line    [NUM_THREADS];
  logic [CL_W-1:0]        match_cline [NUM_THREADS];
  logic [TID_W-1:0]       rr_ptr_reg, rr_ptr_next, sel, cand;
  logic                   sel_valid, accepted;

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      assign grant[gi] = accepted && (sel == TID_W'(gi));

      icache_pf_queue #(
        .DEPTH        (DEPTH),
        .MEM_TAG_BITS (MEM_TAG_BITS),
        .CL_W         (CL_W)
      ) u_queue (
        .clock        (clock),
        .reset        (reset),
        .thread_en    (thread_en[gi]),
        .fetch_addr   (fetch_addr[gi]),
        .cache_hit    (cache_hit[gi]),
        .grant        (grant[gi]),
        .grant_tag    (bus.mem_response),
        .mem_tag      (bus.mem_tag),
        .eligible     (eligible[gi]),
        .req_line     (req_line[gi]),
        .match        (match[gi]),
        .match_cline  (match_cline[gi]),
        .outstanding  (outstanding[gi])
      );
    end
  endgenerate

  // Search starts at the thread after the last grant; a rejected request
  // leaves the pointer alone so the same thread and address are re-presented.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    cand      = '0;
    for (int k = NUM_THREADS-1; k >= 0; k--) begin
      cand = TID_W'((int'(rr_ptr_reg) + k) % NUM_THREADS);
      if (eligible[cand]) begin
        sel_valid = 1'b1;
        sel       = cand;
      end
    end
  end

  assign accepted    = reset && sel_valid && (bus.mem_response != '0);
  assign rr_ptr_next = !accepted ? rr_ptr_reg :
                       (sel == TID_W'(NUM_THREADS-1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) rr_ptr_reg <= '0;
    else        rr_ptr_reg <= rr_ptr_next;
  end

  always_comb begin
    bus.mem_command  = BUS_NONE;
    bus.mem_addr     = '0;
    bus.issue_thread = '0;
    if (reset && sel_valid) begin
      bus.mem_command  = BUS_LOAD;
      bus.mem_addr     = {req_line[sel], 3'b000};
      bus.issue_thread = sel;
    end
  end

  always_comb begin
    bus.wr_en    = 1'b0;
    bus.wr_index = '0;
    bus.wr_tag   = '0;
    for (int t = NUM_THREADS-1; t >= 0; t--) begin
      if (reset && match[t]) begin
        bus.wr_en                  = 1'b1;
        {bus.wr_tag, bus.wr_index} = match_cline[t];
      end
    end
  end

endmodule

// File: tb/tb_icache_prefetch_ctrl.sv
// Directed bench for icache_prefetch_ctrl with hand-computed expectations.
module tb_icache_prefetch_ctrl;
  import icache_pf_pkg::*;

  localparam int NT = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NT-1:0]         thread_en;
  logic [NT-1:0][63:0]   fetch_addr;
  logic [NT-1:0]         cache_hit;
  logic [NT-1:0][2:0]    outstanding;
  int                    n_checks = 0;
  int                    n_errors = 0;
  int                    tags [4] = '{3, 1, 2, 4};

  icache_prefetch_ctrl_if #(.NUM_THREADS(NT), .MEM_TAG_BITS(4), .IDX_BITS(5), .CTAG_BITS(8)) bus_if ();

  icache_prefetch_ctrl #(
    .NUM_THREADS(NT), .DEPTH(4), .MEM_TAG_BITS(4), .IDX_BITS(5), .CTAG_BITS(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .thread_en   (thread_en),
    .fetch_addr  (fetch_addr),
    .cache_hit   (cache_hit),
    .bus         (bus_if),
    .outstanding (outstanding)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_issue(input string tag, input logic [63:0] addr, input int thr);
    $display("issue %s: cmd=%0d thread=%0d addr=0x%0h resp=%0d", tag,
             bus_if.mem_command, bus_if.issue_thread, bus_if.mem_addr, bus_if.mem_response);
    check({tag, "_cmd"}, 64'(bus_if.mem_command), 64'(BUS_LOAD));
    check({tag, "_addr"}, bus_if.mem_addr, addr);
    check({tag, "_thr"}, 64'(bus_if.issue_thread), 64'(thr));
  endtask

  task automatic check_wr(input string tag, input logic en, input int idx, input int ctag);
    $display("return %s: tag=%0d wr_en=%0b index=%0d ctag=0x%0h", tag,
             bus_if.mem_tag, bus_if.wr_en, bus_if.wr_index, bus_if.wr_tag);
    check({tag, "_wr_en"}, 64'(bus_if.wr_en), 64'(en));
    if (en) begin
      check({tag, "_wr_index"}, 64'(bus_if.wr_index), 64'(idx));
      check({tag, "_wr_tag"}, 64'(bus_if.wr_tag), 64'(ctag));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset held while both threads miss: outputs must stay idle.
    reset = 1'b0;
    thread_en = 2'b11;
    cache_hit = 2'b00;
    fetch_addr[0] = 64'h1000;
    fetch_addr[1] = 64'h800;
    bus_if.mem_response = '0;
    bus_if.mem_tag = '0;
    tick(); tick();
    check("rst_cmd", 64'(bus_if.mem_command), 64'(BUS_NONE));
    check("rst_addr", bus_if.mem_addr, 64'h0);
    check("rst_thr", 64'(bus_if.issue_thread), 0);
    check("rst_wr_en", 64'(bus_if.wr_en), 0);
    check("rst_wr_index", 64'(bus_if.wr_index), 0);
    check("rst_wr_tag", 64'(bus_if.wr_tag), 0);
    check("rst_out0", 64'(outstanding[0]), 0);
    check("rst_out1", 64'(outstanding[1]), 0);

    reset = 1'b1;
    thread_en = 2'b00;
    cache_hit = 2'b11;
    fetch_addr[0] = 64'h0;
    tick();

    // Single thread fills its window.
    thread_en = 2'b01;
    cache_hit = 2'b10;
    fetch_addr[0] = 64'h1000;
    for (int i = 0; i < 4; i++) begin
      bus_if.mem_response = 4'(i + 1);
      #1;
      check_issue($sformatf("fill%0d", i), 64'h1000 + 64'(8 * i), 0);
      tick();
    end
    bus_if.mem_response = '0;
    #1;
    check("full_cmd", 64'(bus_if.mem_command), 64'(BUS_NONE));
    check("full_out", 64'(outstanding[0]), 4);
    tick();

    // Out-of-order returns; the head retires only once tag 1 is back.
    for (int r = 0; r < 4; r++) begin
      bus_if.mem_tag = 4'(tags[r]);
      #1;
      check_wr($sformatf("ret%0d", r), 1'b1, tags[r] - 1, 'h10);
      if (r == 1) check("ret_out_r1", 64'(outstanding[0]), 4);
      if (r == 3) begin
        check("ret_out_r3", 64'(outstanding[0]), 3);
        check_issue("ret_reissue", 64'h1020, 0);
      end
      tick();
    end
    bus_if.mem_tag = '0;
    for (int r = 4; r < 7; r++) begin
      #1;
      check($sformatf("drain_out_r%0d", r), 64'(outstanding[0]), 64'(6 - r));
      if (r == 4) check("drain_wr_en", 64'(bus_if.wr_en), 0);
      tick();
    end

    // Back-pressure: rejected three times, then granted once.
    for (int h = 0; h < 3; h++) begin
      bus_if.mem_response = '0;
      #1;
      check_issue($sformatf("hold%0d", h), 64'h1020, 0);
      tick();
    end
    bus_if.mem_response = 4'd5;
    #1;
    check_issue("hold_grant", 64'h1020, 0);
    tick();
    bus_if.mem_response = 4'd1;
    #1;
    check("hold_out", 64'(outstanding[0]), 1);
    check_issue("post_hold0", 64'h1028, 0);
    tick();
    bus_if.mem_response = 4'd2;
    #1;
    check_issue("post_hold1", 64'h1030, 0);
    tick();
    bus_if.mem_response = '0;
    #1;
    check("pre_redir_out", 64'(outstanding[0]), 3);

    // Redirect with requests in flight: issue is immediate, returns are stale.
    fetch_addr[0] = 64'h2000;
    #1;
    check_issue("redir_same", 64'h2000, 0);
    tick();
    #1;
    check("redir_out", 64'(outstanding[0]), 0);
    check_issue("redir_next", 64'h2000, 0);
    bus_if.mem_tag = 4'd1;
    #1;
    check_wr("stale1", 1'b0, 0, 0);
    tick();
    bus_if.mem_tag = 4'd5;
    #1;
    check_wr("stale5", 1'b0, 0, 0);
    bus_if.mem_tag = '0;

    // Reset mid-operation discards the in-flight entry.
    bus_if.mem_response = 4'd3;
    tick();
    bus_if.mem_response = '0;
    #1;
    check("pre_rst_out", 64'(outstanding[0]), 1);
    reset = 1'b0;
    tick();
    check("mid_rst_out", 64'(outstanding[0]), 0);
    reset = 1'b1;
    bus_if.mem_tag = 4'd3;
    #1;
    check_wr("rst_stale", 1'b0, 0, 0);
    tick();
    bus_if.mem_tag = '0;

    // Two threads alternate, then thread 1 is disabled.
    thread_en = 2'b11;
    cache_hit = 2'b00;
    fetch_addr[0] = 64'h100;
    fetch_addr[1] = 64'h800;
    for (int j = 0; j < 4; j++) begin
      bus_if.mem_response = 4'(j + 1);
      #1;
      check_issue($sformatf("rr%0d", j),
                  ((j % 2) ? 64'h800 : 64'h100) + 64'(8 * (j / 2)), j % 2);
      tick();
    end
    bus_if.mem_response = '0;
    #1;
    check("rr_out0", 64'(outstanding[0]), 2);
    check("rr_out1", 64'(outstanding[1]), 2);
    thread_en = 2'b01;
    bus_if.mem_response = 4'd5;
    #1;
    check_issue("t0only0", 64'h110, 0);
    tick();
    bus_if.mem_response = 4'd6;
    #1;
    check("t1_flushed", 64'(outstanding[1]), 0);
    check_issue("t0only1", 64'h118, 0);
    tick();
    bus_if.mem_response = '0;
    #1;
    check("t0_full_cmd", 64'(bus_if.mem_command), 64'(BUS_NONE));
    check("t0_full_out", 64'(outstanding[0]), 4);

    // Wrap: nine back-to-back issue/return cycles through a depth-4 queue.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    thread_en = 2'b01;
    cache_hit = 2'b10;
    fetch_addr[0] = 64'h4000;
    for (int i = 0; i < 9; i++) begin
      bus_if.mem_response = 4'(i + 1);
      bus_if.mem_tag = 4'(i);
      #1;
      check_issue($sformatf("wrap%0d", i), 64'h4000 + 64'(8 * i), 0);
      check($sformatf("wrap%0d_out", i), 64'(outstanding[0]), (i == 0) ? 0 : (i == 1) ? 1 : 2);
      check_wr($sformatf("wrap%0d", i), i > 0, i - 1, 'h40);
      tick();
    end
    bus_if.mem_response = '0;
    bus_if.mem_tag = 4'd9;
    #1;
    check_wr("wrap_last", 1'b1, 8, 'h40);
    check("wrap9_out", 64'(outstanding[0]), 2);
    tick();
    bus_if.mem_tag = '0;
    #1;
    check("wrap10_out", 64'(outstanding[0]), 1);
    tick();
    #1;
    check("wrap11_out", 64'(outstanding[0]), 0);
    check_issue("wrap_next", 64'h4048, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
